// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Multi-channel contact debouncer. It sits directly after the synchroniser
//   and takes its already-synchronised bus, one channel per input line. Each
//   channel publishes a clean registered level. A channel accepts a new level
//   only after STABLE_CYCLES consecutive samples that all differ from the
//   level it is currently holding. A single sample that matches the held
//   level again discards the pending change, so chatter has to settle
//   completely before it is accepted.
//
//   Optional feature macro: DEBOUNCER_EDGES_EN
//     defined     : the Rise_o/Fall_o ports and their strobe registers exist.
//     not defined : only Debounced_o is present. Level behaviour is identical.
//
// Parameters
//   WIDTH          number of independent channels
//   STABLE_CYCLES  consecutive differing samples needed to accept a level (>=1)
//   RESET_VALUE    value loaded into Debounced_o while Reset is low
//
// Ports
//   Clock        in   1      system clock; all logic runs on the rising edge
//   Reset        in   1      synchronous, active-low reset
//   Sync_i       in   WIDTH  synchronised raw inputs
//   Rise_o       out  WIDTH  one-cycle strobe when Debounced_o[k] goes 0->1 (feature only)
//   Fall_o       out  WIDTH  one-cycle strobe when Debounced_o[k] goes 1->0 (feature only)
//   Debounced_o  out  WIDTH  registered debounced level per channel
// -----------------------------------------------------------------------------
module debouncer #(
  parameter int                   WIDTH         = 4,
  parameter int                   STABLE_CYCLES = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE   = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Sync_i,
`ifdef DEBOUNCER_EDGES_EN
  output logic [WIDTH-1:0] Rise_o,
  output logic [WIDTH-1:0] Fall_o,
`endif
  output logic [WIDTH-1:0] Debounced_o
);

  // The counter must be able to hold values up to STABLE_CYCLES. It never
  // reaches that value, because it is cleared on the accepting edge.
  localparam int            CW   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] flip;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Next-state logic for each channel.
  //  - The sample equals the held level: clear the counter and drop any
  //    pending change.
  //  - The sample differs and the counter is below LAST: count one more sample.
  //  - The sample differs and the counter is at LAST: this is the
  //    STABLE_CYCLES-th differing sample, so flip the level and clear the
  //    counter.
  always_comb begin
    flip = '0;
    for (int k = 0; k < WIDTH; k++) begin
      cnt_d[k] = '0;
      if (Sync_i[k] != level_q[k]) begin
        if (cnt_q[k] == LAST) begin
          flip[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
    level_d = level_q ^ flip;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      level_q <= RESET_VALUE;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int k = 0; k < WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign Debounced_o = level_q;

`ifdef DEBOUNCER_EDGES_EN
  // The strobes are registered on the same edge that updates the level, so
  // each strobe lines up with the changed Debounced_o. The direction of the
  // edge is decided from the level held before the flip.
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= flip & ~level_q;
      fall_q <= flip &  level_q;
    end
  end

  assign Rise_o = rise_q;
  assign Fall_o = fall_q;
`endif

endmodule
